esp_host_if: RTL
================

// Module: esp_host_if
// PURPOSE
//  CPU-side I/O interface to the ESP32 command link, at I/O ports F4h (status/control) and F5h (data).
//  It is the stage directly downstream of the boot ROM code. The boot loader polls F4h, drains
//  stale RX bytes, writes 80h to F4h to open a command frame, then streams command bytes via F5h.
//  Contains an RX FIFO (ESP->CPU) and a TX FIFO (CPU->ESP). TX words carry a start-of-frame flag
//  for the link serializer.
// PARAMETERS
//  RX_DEPTH_LOG2  3  RX FIFO depth = 2**RX_DEPTH_LOG2 bytes
//  TX_DEPTH_LOG2  2  TX FIFO depth = 2**TX_DEPTH_LOG2 words (9-bit)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  bus_addr0    in   1  port select: 0 = status/control (F4h), 1 = data (F5h)
//  bus_wrdata   in   8  CPU write data
//  bus_wren     in   1  one-cycle write strobe (one per I/O write)
//  bus_rden     in   1  one-cycle read strobe (one per I/O read); never asserted together with bus_wren
//  bus_rddata   out  8  read data, combinational from bus_addr0 and current state
//  tx_data      out  9  {sof, byte} at TX FIFO head
//  tx_valid     out  1  TX FIFO not empty
//  tx_ready     in   1  link serializer accepts tx_data when tx_valid & tx_ready
//  rx_data      in   8  byte from link deserializer
//  rx_valid     in   1  one-cycle strobe; no backpressure
// BEHAVIOUR
//  Reset: all FIFO pointers and counts 0, ovf=0, sof_pending=0, tx_valid=0; status reads 00h.
//  Status read (addr0=0): {5'b0, ovf, tx_full, rx_nempty}.
//    Bit1 = 1 means the CPU must wait; the boot loader spins while bit1 is set.
//  Control write (addr0=0):
//    bit7=1 -> flush RX FIFO (count=0) and set sof_pending.
//    bit2=1 -> clear ovf.
//    Other bits are ignored.
//  Data read (addr0=1):
//    bus_rddata = RX head, or 00h if empty.
//    bus_rden with addr0=1 pops one byte if non-empty; popping an empty FIFO has no effect.
//  Data write (addr0=1):
//    If TX not full, push {sof_pending, bus_wrdata} and clear sof_pending.
//    If TX full, drop the byte; sof_pending is unchanged and no other state changes.
//  RX push: rx_valid stores rx_data when (count < depth) or when a pop occurs in the same cycle.
//    Otherwise the byte is dropped and ovf is set. ovf is sticky until cleared by a write.
//  Flush and rx_valid in the same cycle: flush wins and the incoming byte is discarded; ovf is not set.
//  TX FIFO is first-word-fall-through.
//    tx_data is valid the cycle after a push; a pop occurs on tx_valid & tx_ready.
//    A push to a full FIFO in the same cycle as a pop is accepted.
//  Pointers wrap modulo depth. Counts are (LOG2+1) bits wide, so full = count==depth, with no
//    pointer-compare ambiguity.
//  Latency:
//    - CPU write to tx_valid: 1 cycle.
//    - rx_valid to status bit0: 1 cycle.
//  Reset mid-operation discards both FIFOs immediately (asynchronously).
// TESTING
//  1. Reset, read F4 -> 00h. Read F5 -> 00h with no state change.
//  2. Write F4=80h, then F5=10h and F5=41h.
//     -> tx_data 110h then 041h, in order, with tx_ready held high.
//  3. Hold tx_ready=0 and write 5 bytes.
//     -> status bit1=1 after the 4th; the 5th is dropped.
//     -> Release tx_ready -> exactly 4 words out, then status bit1=0.
//  4. Inject 9 rx bytes 01h..09h.
//     -> status=05h (ovf set); F5 reads return 01h..08h; then status=04h.
//     -> Write F4=04h -> status 00h.
//  5. Fill RX with 3 bytes, then write F4=80h in the same cycle as rx_valid with AAh.
//     -> status 00h, AAh lost, and the next TX word has sof=1.
//  6. RX full, with F5 read and rx_valid(55h) in the same cycle.
//     -> pop accepted, push accepted, ovf stays 0, count stays 8.

Source files
------------

// File: rtl/esp_host_if.sv
// rtl/esp_host_if.sv - CPU I/O port pair (F4h status/control, F5h data) bridging to the ESP32 command link
//
// Purpose:
//   Presents a status/control register and a data register to the CPU. Bytes
//   received from the ESP32 link land in an RX FIFO that the CPU drains through
//   the data port. Bytes the CPU writes to the data port go to a TX FIFO of
//   9-bit words {sof, byte}; sof marks the first byte after a frame-open
//   control write (bit7) so the link serializer can delimit command frames.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   bus_addr0             0 = status/control, 1 = data
//   bus_wrdata/bus_wren   CPU write data and one-cycle write strobe
//   bus_rden/bus_rddata   one-cycle read strobe, combinational read data
//   tx_data/tx_valid      TX FIFO head word {sof, byte} and not-empty flag
//   tx_ready              serializer accepts the head word when tx_valid is high
//   rx_data/rx_valid      deserializer byte and one-cycle strobe (no backpressure)

module esp_host_if #(
  parameter int RX_DEPTH_LOG2 = 3,
  parameter int TX_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_addr0,
  input  logic [7:0] bus_wrdata,
  input  logic       bus_wren,
  input  logic       bus_rden,
  output logic [7:0] bus_rddata,
  output logic [8:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid
);

  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);

  logic [7:0]               rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [RX_DEPTH_LOG2:0]   rx_cnt;

  logic [8:0]               tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [TX_DEPTH_LOG2:0]   tx_cnt;

  logic ovf;
  logic sof_pending;

  logic ctl_wr, dat_wr, dat_rd;
  logic flush, ovf_clr;
  logic rx_nempty, rx_pop, rx_push, rx_drop;
  logic tx_full, tx_pop, tx_push;

  always_comb begin
    ctl_wr    = bus_wren & ~bus_addr0;
    dat_wr    = bus_wren & bus_addr0;
    dat_rd    = bus_rden & bus_addr0;
    flush     = ctl_wr & bus_wrdata[7];
    ovf_clr   = ctl_wr & bus_wrdata[2];
    rx_nempty = (rx_cnt != '0);
    rx_pop    = dat_rd & rx_nempty;
    // A byte arriving while the FIFO is full still fits if the CPU pops in
    // the same cycle. A flush discards the incoming byte without flagging ovf.
    rx_push   = rx_valid & ~flush & ((rx_cnt != RX_FULL) | rx_pop);
    rx_drop   = rx_valid & ~flush & ~rx_push;
    tx_full   = (tx_cnt == TX_FULL);
    tx_pop    = tx_valid & tx_ready;
    tx_push   = dat_wr & (~tx_full | tx_pop);
  end

  // RX FIFO control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // A fresh overflow takes priority over a clear in the same cycle so that
  // a lost byte is never silently hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf <= 1'b0;
    else if (rx_drop) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // TX FIFO control; a dropped write (FIFO full, no pop) leaves sof_pending alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_cnt      <= '0;
      sof_pending <= 1'b0;
    end else begin
      if (flush)        sof_pending <= 1'b1;
      else if (tx_push) sof_pending <= 1'b0;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= {sof_pending, bus_wrdata};
  end

  // First-word-fall-through head
  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_mem[tx_rp];

  always_comb begin
    if (bus_addr0) bus_rddata = rx_nempty ? rx_mem[rx_rp] : 8'h00;
    else           bus_rddata = {5'b0, ovf, tx_full, rx_nempty};
  end

endmodule
